step_response_monitor: RTL
==========================

Name: step_response_monitor

Overview:
- Downstream measurement stage for the analog filter under emulation; consumes the filter output as a raw signed fixed-point word.
- Extracts step-response figures on-chip so the host reads scalars instead of streaming waveforms:
  - 10%→90% rise time
  - peak value (overshoot)
  - settling time
- Sits on the emulator clock; each qualified sample is one emulation timestep.

Parameters:
- WIDTH, 16, bit width of the signed fixed-point input and of all value parameters/outputs (same format as the filter output).
- V_FINAL, 1000, expected final value.
- V_10, 100, lower rise threshold.
- V_90, 900, upper rise threshold.
- BAND, 20, settling half-band; in-band when |v − V_FINAL| ≤ BAND.
- SETTLE_CYCLES, 4, consecutive in-band valid samples required to declare settled; must be ≥1.
- CW, 8, width of time counters.
- MAX_CYCLES, 255, timeout in valid samples; must be ≤ 2^CW−1.

Ports:
- emu_clk  input  1  emulator clock; all logic on rising edge.
- emu_rst  input  1  reset, synchronous, active-high.
- v_in  input  WIDTH  signed raw filter output sample.
- in_valid  input  1  v_in is a new timestep sample this cycle.
- start  input  1  one-cycle pulse: step applied; arm a measurement.
- busy  output  1  measurement in progress.
- done  output  1  measurement finished (settled or timed out); held until next start.
- timeout  output  1  measurement ended by MAX_CYCLES.
- rise_cycles  output  CW  valid samples from first sample ≥V_10 to first sample ≥V_90.
- settle_cycles  output  CW  sample index of the first sample of the qualifying in-band run.
- peak  output  WIDTH  signed maximum of v_in over the measurement.

Behaviour:
- Reset (any state, including mid-measurement):
  - state IDLE.
  - busy, done, timeout, rise_cycles, settle_cycles, peak all 0.
  - internal t, t10, run all 0.
- States: IDLE, WAIT10, RISE, SETTLE, FIN.
  - busy = 1 in WAIT10/RISE/SETTLE.
  - done = 1 in FIN only.
- start handling:
  - In IDLE or FIN: clear done, timeout, rise_cycles, settle_cycles, t, run; set peak to most-negative WIDTH value; go to WAIT10 next cycle.
  - While busy: start is ignored.
  - A sample on the start cycle is not measured.
- Sample index t:
  - The first valid sample after arming has t=0.
  - t increments after each valid sample while busy.
  - Cycles with in_valid=0 change nothing.
- Peak:
  - On every valid sample while busy, peak ← max(peak, v_in), signed compare.
  - Peak updates on the same sample that causes a transition.
- Timeout is checked first on each valid sample:
  - If t == MAX_CYCLES: go to FIN, timeout=1, settle_cycles=0; rise_cycles keeps whatever was recorded.
- WIRE10 behaviour (state WAIT10): if v_in ≥ V_10 then t10 ← t.
  - Same sample also ≥ V_90: rise_cycles=0, go to SETTLE and evaluate the band on that sample.
  - Otherwise go to RISE.
- RISE: if v_in ≥ V_90, rise_cycles ← t − t10 and go to SETTLE; the band is evaluated on that same sample.
- SETTLE:
  - Compute diff = v_in − V_FINAL at WIDTH+1 bits, no overflow.
  - inband = −BAND ≤ diff ≤ BAND.
  - If inband: run ← run+1; otherwise run ← 0.
  - When run+1 == SETTLE_CYCLES on an in-band sample: settle_cycles ← t − SETTLE_CYCLES + 1, go to FIN.
- FIN: all outputs hold until start or emu_rst.
- Output latency: results are registered and visible the cycle after the deciding sample.
- Counters never wrap (guaranteed by the timeout).

Test Plan:
- Default params; ramp v=50·t (t=0..20) then hold 1000, in_valid=1 every cycle → rise_cycles=16 (t10=2, t90=18), settle_cycles=20, peak=1000, done=1, timeout=0 after t=23.
- Samples 1200,1150,1100,1050,1030, then 1010 held → rise_cycles=0, settle_cycles=5, peak=1200, done after t=8.
- Stimulus of scenario 1 with in_valid toggling 1,0,1,0 → identical outputs to scenario 1; busy held throughout.
- Band break: step to 1000 for samples t=0..2, 1050 at t=3, 1000 from t=4 → settle_cycles=4, not 0.
- v_in held at −5 for 300 cycles → timeout=1, done=1 at t=255, peak=−5, rise_cycles=0, settle_cycles=0.
- Scenario 1 with emu_rst at t=10 → all outputs 0 next cycle, state IDLE.
  - start pulsed at t=5 of a later run is ignored; that run's results match scenario 1.

Source files
------------

// File: rtl/step_response_monitor.sv
// Step-response monitor: measures 10-90 rise time, peak and settling time
// of a filter output stream, one qualified sample per emulation timestep.
module step_response_monitor #(
  parameter int                      WIDTH         = 16,
  parameter logic signed [WIDTH-1:0] V_FINAL       = WIDTH'(1000),
  parameter logic signed [WIDTH-1:0] V_10          = WIDTH'(100),
  parameter logic signed [WIDTH-1:0] V_90          = WIDTH'(900),
  parameter logic signed [WIDTH-1:0] BAND          = WIDTH'(20),
  parameter int                      SETTLE_CYCLES = 4,
  parameter int                      CW            = 8,
  parameter int                      MAX_CYCLES    = 255
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic signed [WIDTH-1:0] v_in,
  input  logic                    in_valid,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [CW-1:0]           rise_cycles,
  output logic [CW-1:0]           settle_cycles,
  output logic signed [WIDTH-1:0] peak
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT10,
    RISE,
    SETTLE,
    FIN
  } state_t;

  localparam logic [CW-1:0] SC    = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] MAX_T = CW'(MAX_CYCLES);
  localparam logic signed [WIDTH-1:0] PEAK_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH:0] BAND_X = {BAND[WIDTH-1], BAND};

  state_t state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic [CW-1:0] t10_q, t10_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] rise_q, rise_d;
  logic [CW-1:0] settle_q, settle_d;
  logic signed [WIDTH-1:0] peak_q, peak_d;
  logic timeout_q, timeout_d;

  logic signed [WIDTH:0] diff;
  logic inband;
  logic [CW-1:0] run_inc;
  logic eval;

  // One extra bit keeps the deviation exact for any input word
  assign diff = {v_in[WIDTH-1], v_in} - {V_FINAL[WIDTH-1], V_FINAL};
  assign inband = (diff >= -BAND_X) && (diff <= BAND_X);
  assign run_inc = run_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    t10_d     = t10_q;
    run_d     = run_q;
    rise_d    = rise_q;
    settle_d  = settle_q;
    peak_d    = peak_q;
    timeout_d = timeout_q;
    eval      = 1'b0;
    unique case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d   = WAIT10;
          t_d       = '0;
          t10_d     = '0;
          run_d     = '0;
          rise_d    = '0;
          settle_d  = '0;
          timeout_d = 1'b0;
          peak_d    = PEAK_MIN;
        end
      end
      WAIT10, RISE, SETTLE: begin
        if (in_valid) begin
          if (v_in > peak_q) peak_d = v_in;
          if (t_q == MAX_T) begin
            state_d   = FIN;
            timeout_d = 1'b1;
            settle_d  = '0;
          end else begin
            t_d = t_q + CW'(1);
            case (state_q)
              WAIT10: begin
                if (v_in >= V_10) begin
                  t10_d = t_q;
                  if (v_in >= V_90) begin
                    rise_d = '0;
                    eval   = 1'b1;
                  end else begin
                    state_d = RISE;
                  end
                end
              end
              RISE: begin
                if (v_in >= V_90) begin
                  rise_d = t_q - t10_q;
                  eval   = 1'b1;
                end
              end
              SETTLE: eval = 1'b1;
              default: ;
            endcase
            // Band is judged on the very sample that crossed V_90
            if (eval) begin
              state_d = SETTLE;
              if (inband) begin
                run_d = run_inc;
                if (run_inc == SC) begin
                  settle_d = t_q - SC + CW'(1);
                  state_d  = FIN;
                end
              end else begin
                run_d = '0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      t10_q     <= '0;
      run_q     <= '0;
      rise_q    <= '0;
      settle_q  <= '0;
      peak_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      t10_q     <= t10_d;
      run_q     <= run_d;
      rise_q    <= rise_d;
      settle_q  <= settle_d;
      peak_q    <= peak_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy          = (state_q == WAIT10) || (state_q == RISE) ||
                         (state_q == SETTLE);
  assign done          = (state_q == FIN);
  assign timeout       = timeout_q;
  assign rise_cycles   = rise_q;
  assign settle_cycles = settle_q;
  assign peak          = peak_q;

endmodule
